// File: rtl/sync_copy_fork_n_if.sv
// Token handshake bundle between a producer, the copy fork and its consumer branches.
// master = producer/consumer side, slave = the fork itself.
interface sync_copy_fork_n_if #(
    parameter int N_BRANCH = 3
);
    logic                i_drive;
    logic                o_ready;
    logic                o_free;
    logic [N_BRANCH-1:0] o_driveNext;
    logic [N_BRANCH-1:0] i_freeNext;
    logic                o_busy;
    logic                o_overflow;
    logic                o_underflow;

    modport master (
        output i_drive, i_freeNext,
        input  o_ready, o_free, o_driveNext, o_busy, o_overflow, o_underflow
    );

    modport slave (
        input  i_drive, i_freeNext,
        output o_ready, o_free, o_driveNext, o_busy, o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_copy_fork_n.sv
// N-way copy fork: broadcasts each accepted drive token to every branch and returns one
// upstream free per completed token (join-all or join-any), tracking up to DEPTH tokens.
module sync_copy_fork_n #(
    parameter int N_BRANCH = 3,
    parameter int DEPTH    = 4,
    parameter bit JOIN_ALL = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sync_copy_fork_n_if.slave bus
);
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]    tok_q, tok_d;
    logic [CNT_W-1:0]    fa_q [N_BRANCH];
    logic [CNT_W-1:0]    fa_d [N_BRANCH];
    logic [N_BRANCH-1:0] drive_next_q, drive_next_d;
    logic                free_q, free_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                ready;
    logic                acc;
    logic                complete;
    logic                bad_free;
    logic [N_BRANCH-1:0] legal;

    // Readiness looks only at registered tok, never at same-cycle frees.
    assign ready = !i_rst && (tok_q < DEPTH_C);
    assign acc   = bus.i_drive && ready;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        legal    = '0;
        complete = 1'b0;
        bad_free = 1'b0;
        if (JOIN_ALL) begin
            complete = 1'b1;
            for (int k = 0; k < N_BRANCH; k++) begin
                legal[k] = bus.i_freeNext[k] && (fa_q[k] < tok_q);
                complete = complete && (fa_q[k] != '0);
            end
            bad_free = |(bus.i_freeNext & ~legal);
        end else begin
            complete = (|bus.i_freeNext) && (tok_q != '0);
            bad_free = (|bus.i_freeNext) && (tok_q == '0);
        end

        tok_d = tok_q + CNT_W'(acc) - CNT_W'(complete);
        for (int k = 0; k < N_BRANCH; k++) begin
            fa_d[k] = JOIN_ALL ? (fa_q[k] + CNT_W'(legal[k]) - CNT_W'(complete)) : '0;
        end
        drive_next_d = {N_BRANCH{acc}};
        free_d       = complete;
        overflow_d   = overflow_q || (bus.i_drive && !ready);
        underflow_d  = underflow_q || bad_free;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tok_q        <= '0;
            // NOTE: fa is a handful of counters rather than a RAM, so it is reset with the rest.
            for (int k = 0; k < N_BRANCH; k++) begin
                fa_q[k] <= '0;
            end
            drive_next_q <= '0;
            free_q       <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            tok_q        <= tok_d;
            for (int k = 0; k < N_BRANCH; k++) begin
                fa_q[k] <= fa_d[k];
            end
            drive_next_q <= drive_next_d;
            free_q       <= free_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_free      = free_q;
    assign bus.o_driveNext = drive_next_q;
    assign bus.o_busy      = (tok_q != '0);
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_sync_copy_fork_n.sv
// Bench for sync_copy_fork_n: a join-all and a join-any instance run side by side against
// a token-queue reference model, through directed scenarios and a randomized phase.
module tb_sync_copy_fork_n;
    localparam int N     = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_copy_fork_n_if #(.N_BRANCH(N)) ifa ();
    sync_copy_fork_n_if #(.N_BRANCH(N)) ifb ();

    sync_copy_fork_n #(.N_BRANCH(N), .DEPTH(DEPTH), .JOIN_ALL(1'b1)) dut_all (
        .i_clk(clk), .i_rst(rst), .bus(ifa.slave)
    );
    sync_copy_fork_n #(.N_BRANCH(N), .DEPTH(DEPTH), .JOIN_ALL(1'b0)) dut_any (
        .i_clk(clk), .i_rst(rst), .bus(ifb.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Join-all model: one entry per outstanding token, holding which branches have freed it.
    logic [N-1:0] a_q[$];
    logic [N-1:0] a_dn;
    logic         a_free, a_ovf, a_unf;
    // Join-any model: just the number of outstanding tokens.
    int           b_cnt;
    logic [N-1:0] b_dn;
    logic         b_free, b_ovf, b_unf;

    int cyc, a_pulses, a_first, b_pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int a_pending(input int k);
        int n = 0;
        for (int i = 0; i < a_q.size(); i++) if (!a_q[i][k]) n++;
        return n;
    endfunction

    task automatic model_all(input logic r, input logic d, input logic [N-1:0] f, input logic rdy);
        logic         c;
        logic         acc;
        logic [N-1:0] m;
        int           idx;
        if (r) begin
            a_q.delete();
            a_dn = '0; a_free = 1'b0; a_ovf = 1'b0; a_unf = 1'b0;
            return;
        end
        acc = d && rdy;
        c   = (a_q.size() > 0) && (a_q[0] == '1);
        // Each branch frees its own tokens oldest-first.
        for (int k = 0; k < N; k++) begin
            if (f[k]) begin
                idx = -1;
                for (int i = 0; i < a_q.size(); i++) if (idx < 0 && !a_q[i][k]) idx = i;
                if (idx >= 0) begin
                    m = a_q[idx]; m[k] = 1'b1; a_q[idx] = m;
                end else begin
                    a_unf = 1'b1;
                end
            end
        end
        if (c) void'(a_q.pop_front());
        if (acc) a_q.push_back('0);
        a_dn   = {N{acc}};
        a_free = c;
        if (d && !rdy) a_ovf = 1'b1;
    endtask

    task automatic model_any(input logic r, input logic d, input logic [N-1:0] f, input logic rdy);
        logic c;
        logic acc;
        if (r) begin
            b_cnt = 0;
            b_dn = '0; b_free = 1'b0; b_ovf = 1'b0; b_unf = 1'b0;
            return;
        end
        acc = d && rdy;
        c   = (f != '0) && (b_cnt > 0);
        if ((f != '0) && (b_cnt == 0)) b_unf = 1'b1;
        b_cnt  = b_cnt + int'(acc) - int'(c);
        b_dn   = {N{acc}};
        b_free = c;
        if (d && !rdy) b_ovf = 1'b1;
    endtask

    task automatic cycle(input logic r, input logic d, input logic [N-1:0] fa, input logic [N-1:0] fb);
        logic ra, rb;
        rst = r;
        ifa.i_drive = d; ifa.i_freeNext = fa;
        ifb.i_drive = d; ifb.i_freeNext = fb;
        #1;
        ra = !r && (a_q.size() < DEPTH);
        rb = !r && (b_cnt < DEPTH);
        check("a_ready", ifa.o_ready, ra);
        check("b_ready", ifb.o_ready, rb);
        model_all(r, d, fa, ra);
        model_any(r, d, fb, rb);
        @(posedge clk);
        #1;
        check("a_drive_next", ifa.o_driveNext, a_dn);
        check("a_free", ifa.o_free, a_free);
        check("a_busy", ifa.o_busy, a_q.size() != 0);
        check("a_overflow", ifa.o_overflow, a_ovf);
        check("a_underflow", ifa.o_underflow, a_unf);
        check("b_drive_next", ifb.o_driveNext, b_dn);
        check("b_free", ifb.o_free, b_free);
        check("b_busy", ifb.o_busy, b_cnt != 0);
        check("b_overflow", ifb.o_overflow, b_ovf);
        check("b_underflow", ifb.o_underflow, b_unf);
        if (ifa.o_free) begin
            a_pulses++;
            if (a_first < 0) a_first = cyc + 1;
        end
        if (ifb.o_free) b_pulses++;
        cyc++;
    endtask

    task automatic begin_phase();
        cyc = 0; a_pulses = 0; a_first = -1; b_pulses = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        b_cnt = 0;
        begin_phase();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, '0, '0);

        // One token, branches free out of order at cycles 3, 5, 8.
        begin_phase();
        cycle(1'b0, 1'b1, '0, '0);
        idle(2);
        cycle(1'b0, 1'b0, 3'b001, '0);
        idle(1);
        cycle(1'b0, 1'b0, 3'b100, '0);
        idle(2);
        cycle(1'b0, 1'b0, 3'b010, '0);
        idle(3);
        check("t1_pulses", a_pulses, 1);
        check("t1_free_cycle", a_first, 10);
        check("t1_busy", ifa.o_busy, 0);

        // Fill to DEPTH, overflow, then release the oldest token on all branches at once.
        cycle(1'b1, 1'b0, '0, '0);
        begin_phase();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, '0);
        check("t2_overflow", ifa.o_overflow, 1);
        cycle(1'b0, 1'b0, 3'b111, '0);
        idle(3);
        check("t2_pulses", a_pulses, 1);
        check("t2_free_cycle", a_first, 7);

        // Skewed branches: branch 0 races ahead, branches 1 and 2 catch up together.
        cycle(1'b1, 1'b0, '0, '0);
        begin_phase();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'b001, '0);
        check("t3_no_early_free", a_pulses, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'b110, '0);
        idle(4);
        check("t3_pulses", a_pulses, 3);
        check("t3_free_cycle", a_first, 8);

        // Underflow from idle, then a second free on the same branch of a single token.
        cycle(1'b1, 1'b0, '0, '0);
        begin_phase();
        cycle(1'b0, 1'b0, 3'b010, 3'b010);
        check("t4_underflow_idle_a", ifa.o_underflow, 1);
        check("t4_underflow_idle_b", ifb.o_underflow, 1);
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 3'b010, '0);
        check("t4_no_underflow_yet", ifa.o_underflow, 0);
        cycle(1'b0, 1'b0, 3'b010, '0);
        check("t4_underflow_repeat", ifa.o_underflow, 1);

        // Join-any: a multi-bit free completes exactly one token.
        cycle(1'b1, 1'b0, '0, '0);
        begin_phase();
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, '0, 3'b101);
        check("t5_first_pulse", b_pulses, 1);
        check("t5_busy", ifb.o_busy, 1);
        cycle(1'b0, 1'b0, '0, 3'b010);
        idle(2);
        check("t5_pulses", b_pulses, 2);
        check("t5_idle", ifb.o_busy, 0);

        // Reset with tokens in flight, then a fresh token completes normally.
        cycle(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 3'b011, 3'b001);
        cycle(1'b1, 1'b1, 3'b100, '0);
        begin_phase();
        cycle(1'b0, 1'b1, '0, '0);
        idle(1);
        cycle(1'b0, 1'b0, 3'b111, 3'b001);
        idle(3);
        check("t6_pulses", a_pulses, 1);
        check("t6_free_cycle", a_first, 4);
        check("t6_any_pulses", b_pulses, 1);

        // Randomized traffic with occasional resets and occasional illegal frees.
        for (int it = 0; it < 3000; it++) begin
            logic         r, d;
            logic [N-1:0] fa, fb;
            r = ($urandom_range(0, 149) == 0);
            d = ($urandom_range(0, 1) == 0);
            for (int k = 0; k < N; k++) begin
                fa[k] = ((a_pending(k) > 0) && ($urandom_range(0, 1) == 0)) ||
                        ($urandom_range(0, 79) == 0);
            end
            fb = '0;
            if ((b_cnt > 0) && ($urandom_range(0, 1) == 0)) fb = N'($urandom_range(1, (1 << N) - 1));
            else if ($urandom_range(0, 99) == 0) fb = 3'b001;
            cycle(r, d, fa, fb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sync_copy_fork_n.md
Name: sync_copy_fork_n

Overview:
Clocked, parametrised N-way copy fork for the synchronous micropipeline library. Each accepted drive token is broadcast as a one-cycle pulse to every branch. The block tracks up to DEPTH outstanding tokens. It returns a free pulse upstream either when every branch has freed the oldest token (join-all) or on the first branch free (join-any, the original OR-free behaviour). It sits between a producer stage and N consumer stages that run at different rates.

Parameters:
N_BRANCH, 3, number of output branches (>=2)
DEPTH, 4, maximum tokens outstanding (issued but not completed) (>=1)
JOIN_ALL, 1, 1 = token completes when all branches have freed it; 0 = token completes on first free from any branch
CNT_W, $clog2(DEPTH+1), width of the token and free counters (derived, do not override)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous reset, active-high
i_drive  input  1  one-cycle token pulse from upstream
o_ready  output  1  high = i_drive is accepted this cycle
o_free  output  1  one-cycle pulse upstream per completed token
o_driveNext  output  N_BRANCH  per-branch token pulse
i_freeNext  input  N_BRANCH  per-branch free pulse
o_busy  output  1  tok != 0
o_overflow  output  1  sticky: drive arrived while o_ready low
o_underflow  output  1  sticky: illegal free seen

Behaviour:
- State: tok (0..DEPTH) counts tokens issued and not completed. Per-branch fa[k] (0..tok) counts frees received for uncompleted tokens; fa is used only when JOIN_ALL=1.
- Reset (i_rst high at an edge):
  - tok, fa, o_driveNext, o_free, o_overflow and o_underflow are cleared to 0.
  - While i_rst is high, o_ready=0 and i_drive is ignored; this does not set overflow.
  - Reset mid-operation discards all outstanding tokens, and no o_free is emitted for them.
- o_ready = !i_rst && (tok < DEPTH). It is combinational from registers and does not depend on same-cycle frees.
- Accept: acc = i_drive && o_ready.
  - At the edge: o_driveNext <= {N_BRANCH{acc}}, giving 1-cycle latency, all bits identical.
  - tok increments.
- i_drive && !o_ready sets o_overflow. The token is dropped, and no driveNext or tok change occurs.
- JOIN_ALL=1:
  - A free bit k is legal iff fa[k] < tok, using register values. A legal free gives fa[k]+1. An illegal free sets o_underflow and is ignored.
  - Completion C = AND over k of (fa[k] != 0).
  - At the edge: o_free <= C; tok <= tok + acc - C; fa[k] <= fa[k] + legal[k] - C.
  - Latency from the last branch free of a token to o_free is 2 cycles. A token freed by all branches in the same cycle also gives o_free 2 cycles later.
  - Back-to-back completions are possible: one per cycle while all fa[k] >= 1.
- JOIN_ALL=0:
  - C = (|i_freeNext) && tok != 0. At the edge: o_free <= C; tok <= tok + acc - C.
  - Multiple free bits in one cycle complete exactly one token.
  - Any free bit while tok == 0 sets o_underflow.
  - Latency is 1 cycle.
- Simultaneous accept and completion: tok is unchanged. o_ready uses the pre-edge tok, so a full fork does not accept in the completion cycle.
- Freed branches never need to free in order with respect to each other. Each branch must free its own tokens in issue order.
- Sticky flags clear only on reset.

Test Plan:
1. Join-all, N=3, DEPTH=4: one drive at cycle 0; frees on branches 0, 2, 1 at cycles 3, 5, 8 -> o_driveNext=3'b111 at cycle 1; o_free pulse at cycle 10; tok returns to 0; o_busy low.
2. Fill: 4 back-to-back drives with no frees -> o_ready low after the 4th. A 5th drive sets o_overflow=1, gives no 5th driveNext pulse, and tok stays 4. Then free all branches of token 0 together -> o_free pulse 2 cycles later, and o_ready high again from that edge.
3. Skewed branches: 3 tokens. Branch 0 frees all 3 immediately; branches 1 and 2 free later, one per cycle together -> exactly 3 o_free pulses on consecutive cycles, and none before branches 1 and 2 catch up.
4. Underflow: from idle, pulse i_freeNext=3'b010 -> o_underflow=1; tok and fa unchanged; no o_free. In join-all with tok=1 and fa[1]=1, another free on branch 1 -> o_underflow=1.
5. Join-any (JOIN_ALL=0): 2 tokens outstanding, i_freeNext=3'b101 in one cycle -> one o_free pulse 1 cycle later, tok=1. Next, i_freeNext=3'b010 -> second o_free pulse, tok=0.
6. Reset mid-operation: 3 tokens outstanding, partial frees, assert i_rst for 1 cycle -> all outputs 0 and o_ready low during reset. After release, o_ready=1, tok=0, no stray o_free, and a new drive completes normally.
